// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported unified memory between the core's
//               instruction-fetch (IF) stage and its data-memory (DM) stage.
//               Data requests win arbitration by default. A starvation guard
//               forces a fetch grant after STARVE_LIMIT consecutive data grants
//               made while a fetch was waiting. Exactly one memory transaction
//               is outstanding at a time, and each response is routed back to
//               the requester that owns it. A fetch flush drops the response
//               of an in-flight fetch; the memory transaction still completes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1             clock, rising edge
//   rst          in   1             synchronous reset, active low
//   i_if_req     in   1             fetch request, held with address until ready
//   i_if_addr    in   ADDR_WIDTH    fetch address
//   i_if_flush   in   1             discard the response of the in-flight fetch
//   o_if_ready   out  1             fetch request accepted (single-cycle pulse)
//   o_if_rvalid  out  1             fetch data valid (single-cycle pulse)
//   o_if_rdata   out  DATA_WIDTH    fetch data
//   i_dm_req     in   1             data request, held with payload until ready
//   i_dm_we      in   1             1 = write
//   i_dm_addr    in   ADDR_WIDTH    data address
//   i_dm_wdata   in   DATA_WIDTH    write data
//   i_dm_wstrb   in   DATA_WIDTH/8  byte strobes
//   o_dm_ready   out  1             data request accepted (single-cycle pulse)
//   o_dm_rvalid  out  1             read data or write ack (single-cycle pulse)
//   o_dm_rdata   out  DATA_WIDTH    read data, 0 for writes
//   o_mem_req    out  1             memory request, held until i_mem_gnt
//   o_mem_we     out  1             latched write enable
//   o_mem_addr   out  ADDR_WIDTH    latched address
//   o_mem_wdata  out  DATA_WIDTH    latched write data
//   o_mem_wstrb  out  DATA_WIDTH/8  latched byte strobes
//   i_mem_gnt    in   1             memory accepts the request
//   i_mem_rvalid in   1             memory response (read data or write ack)
//   i_mem_rdata  in   DATA_WIDTH    memory response data
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // instruction-fetch port
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                    i_if_flush,
    output logic                    o_if_ready,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    // data-memory port
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_wstrb,
    output logic                    o_dm_ready,
    output logic                    o_dm_rvalid,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    // unified memory port
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_STRB_W = DATA_WIDTH / 8;

    // A limit of 0 still needs a one-bit counter so the logic stays legal.
    // The counter then never advances because fetch always wins.
    localparam int c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT   = c_CNT_W'(STARVE_LIMIT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    localparam logic c_OWN_IF = 1'b0;
    localparam logic c_OWN_DM = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_owner;
    logic                  r_drop;
    logic [c_CNT_W-1:0]    r_starve_cnt;

    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [c_STRB_W-1:0]   r_mem_wstrb;

    logic                  r_if_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic                  r_dm_rvalid;
    logic [DATA_WIDTH-1:0] r_dm_rdata;

    // ------------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_idle;
    logic       w_dm_wins;
    logic       w_grant_if;
    logic       w_grant_dm;
    logic       w_grant;
    logic       w_flush_hit;
    logic       w_resp_done;
    logic       w_if_drop;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Arbitration is gated with rst. This keeps a ready pulse from appearing
    // for a request that the reset edge would then discard.
    assign w_idle = (r_state == c_S_IDLE) && rst;

    // Data wins unless a fetch is waiting and the guard has already let
    // STARVE_LIMIT data grants pass it.
    assign w_dm_wins  = i_dm_req && (!i_if_req || (r_starve_cnt < c_LIMIT));
    assign w_grant_dm = w_idle && w_dm_wins;
    assign w_grant_if = w_idle && i_if_req && !w_dm_wins;
    assign w_grant    = w_grant_dm || w_grant_if;

    // A flush only matters while the fetch is actually in flight.
    assign w_flush_hit = i_if_flush && (r_owner == c_OWN_IF) && (r_state != c_S_IDLE);
    assign w_resp_done = (r_state == c_S_RESP) && i_mem_rvalid;

    // A flush that arrives in the same cycle as the response also drops it.
    assign w_if_drop   = r_drop || i_if_flush;

    // ------------------------------------------------------------------------
    // Transaction sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (i_mem_gnt) begin
                    w_state_nxt = c_S_RESP;
                end
            end
            c_S_RESP: begin
                if (i_mem_rvalid) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Payload, ownership, starvation guard and response routing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner      <= c_OWN_IF;
            r_drop       <= 1'b0;
            r_starve_cnt <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_if_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rvalid  <= 1'b0;
            r_dm_rdata   <= '0;
        end else begin
            // Response outputs are single-cycle pulses. The data is zeroed
            // whenever it is not valid.
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rvalid <= 1'b0;
            r_dm_rdata  <= '0;

            if (w_grant_if) begin
                r_owner      <= c_OWN_IF;
                r_drop       <= 1'b0;
                r_mem_we     <= 1'b0;
                r_mem_addr   <= i_if_addr;
                r_mem_wdata  <= '0;
                r_mem_wstrb  <= '0;
                r_starve_cnt <= '0;
            end else if (w_grant_dm) begin
                r_owner     <= c_OWN_DM;
                r_drop      <= 1'b0;
                r_mem_we    <= i_dm_we;
                r_mem_addr  <= i_dm_addr;
                r_mem_wdata <= i_dm_wdata;
                r_mem_wstrb <= i_dm_wstrb;
                // Only data grants that bypass a waiting fetch count toward
                // starvation.
                if (i_if_req && (r_starve_cnt != c_LIMIT)) begin
                    r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
                end
            end

            if (w_flush_hit) begin
                r_drop <= 1'b1;
            end

            if (w_resp_done) begin
                r_drop <= 1'b0;
                if (r_owner == c_OWN_IF) begin
                    if (!w_if_drop) begin
                        r_if_rvalid <= 1'b1;
                        r_if_rdata  <= i_mem_rdata;
                    end
                end else begin
                    r_dm_rvalid <= 1'b1;
                    r_dm_rdata  <= r_mem_we ? '0 : i_mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_if_ready  = w_grant_if;
    assign o_dm_ready  = w_grant_dm;
    assign o_if_rvalid = r_if_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rvalid = r_dm_rvalid;
    assign o_dm_rdata  = r_dm_rdata;

    assign o_mem_req   = (r_state == c_S_REQ);
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wstrb = r_mem_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. It runs directed
//               scenarios first, then randomised traffic. A transaction-level
//               reference model predicts the ready pulses, the memory payload
//               and the responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk;
    logic          rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          i_if_flush;
    logic          o_if_ready;
    logic          o_if_rvalid;
    logic [DW-1:0] o_if_rdata;
    logic          i_dm_req;
    logic          i_dm_we;
    logic [AW-1:0] i_dm_addr;
    logic [DW-1:0] i_dm_wdata;
    logic [SW-1:0] i_dm_wstrb;
    logic          o_dm_ready;
    logic          o_dm_rvalid;
    logic [DW-1:0] o_dm_rdata;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [SW-1:0] o_mem_wstrb;
    logic          i_mem_gnt;
    logic          i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;

    int checks;
    int errors;

    // Reference-model state used by the contention and random phases.
    int            mcnt;
    int            ng;
    int            phase;          // 0 free, 1 waiting for gnt, 2 waiting for response
    logic          if_hold, dm_hold;
    logic          win_if, win_dm;
    logic          t_if, t_we, t_drop;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata;
    logic [SW-1:0] t_wstrb;
    logic          e_if_rv, e_dm_rv;
    logic [DW-1:0] e_if_rd, e_dm_rd;

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .i_if_flush   (i_if_flush),
        .o_if_ready   (o_if_ready),
        .o_if_rvalid  (o_if_rvalid),
        .o_if_rdata   (o_if_rdata),
        .i_dm_req     (i_dm_req),
        .i_dm_we      (i_dm_we),
        .i_dm_addr    (i_dm_addr),
        .i_dm_wdata   (i_dm_wdata),
        .i_dm_wstrb   (i_dm_wstrb),
        .o_dm_ready   (o_dm_ready),
        .o_dm_rvalid  (o_dm_rvalid),
        .o_dm_rdata   (o_dm_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. Outputs are sampled 4 ns later,
    // well away from the next edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clr();
        i_if_req     = 1'b0;
        i_if_addr    = '0;
        i_if_flush   = 1'b0;
        i_dm_req     = 1'b0;
        i_dm_we      = 1'b0;
        i_dm_addr    = '0;
        i_dm_wdata   = '0;
        i_dm_wstrb   = '0;
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        clr();

        // ---------------- reset state ----------------
        nxt();
        nxt();
        settle();
        chk("rst_mem_req",   o_mem_req,   0);
        chk("rst_mem_we",    o_mem_we,    0);
        chk("rst_mem_addr",  o_mem_addr,  0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        chk("rst_mem_wstrb", o_mem_wstrb, 0);
        chk("rst_if_ready",  o_if_ready,  0);
        chk("rst_dm_ready",  o_dm_ready,  0);
        chk("rst_if_rvalid", o_if_rvalid, 0);
        chk("rst_if_rdata",  o_if_rdata,  0);
        chk("rst_dm_rvalid", o_dm_rvalid, 0);
        chk("rst_dm_rdata",  o_dm_rdata,  0);
        nxt();
        rst = 1'b1;

        // ---------------- single fetch ----------------
        i_if_req = 1'b1; i_if_addr = 32'h100;
        settle();
        chk("t1_if_ready_c0", o_if_ready, 1);
        chk("t1_dm_ready_c0", o_dm_ready, 0);
        chk("t1_mem_req_c0",  o_mem_req,  0);
        nxt();
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        settle();
        chk("t1_mem_req_c1",  o_mem_req,  1);
        chk("t1_mem_addr",    o_mem_addr, 32'h100);
        chk("t1_mem_we",      o_mem_we,   0);
        chk("t1_mem_wstrb",   o_mem_wstrb, 0);
        chk("t1_if_ready_c1", o_if_ready, 0);
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h00500093;
        settle();
        chk("t1_mem_req_c2",   o_mem_req,   0);
        chk("t1_if_rvalid_c2", o_if_rvalid, 0);
        nxt();
        i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        settle();
        chk("t1_if_rvalid_c3", o_if_rvalid, 1);
        chk("t1_if_rdata_c3",  o_if_rdata,  32'h00500093);
        chk("t1_dm_rvalid_c3", o_dm_rvalid, 0);
        nxt();
        settle();
        chk("t1_if_rvalid_c4", o_if_rvalid, 0);
        nxt();

        // ---------------- write ----------------
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h2000;
        i_dm_wdata = 32'hDEADBEEF; i_dm_wstrb = 4'hF;
        settle();
        chk("t2_dm_ready", o_dm_ready, 1);
        chk("t2_if_ready", o_if_ready, 0);
        nxt();
        clr(); i_mem_gnt = 1'b1;
        settle();
        chk("t2_mem_req",   o_mem_req,   1);
        chk("t2_mem_we",    o_mem_we,    1);
        chk("t2_mem_addr",  o_mem_addr,  32'h2000);
        chk("t2_mem_wdata", o_mem_wdata, 32'hDEADBEEF);
        chk("t2_mem_wstrb", o_mem_wstrb, 4'hF);
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t2_dm_rvalid", o_dm_rvalid, 1);
        chk("t2_dm_rdata",  o_dm_rdata,  0);
        chk("t2_if_rvalid", o_if_rvalid, 0);
        nxt();

        // ---------------- contention ----------------
        // The guard count starts at 0 here: the fetch grant cleared it and the
        // write was granted with no fetch waiting.
        mcnt = 0;
        ng   = 0;
        i_if_req = 1'b1; i_if_addr = 32'h400;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h800;
        i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            settle();
            chk("t3_both_rvalid", o_if_rvalid & o_dm_rvalid, 0);
            if (o_if_ready || o_dm_ready) begin
                win_if = (mcnt >= LIMIT);
                chk($sformatf("t3_grant%0d_if", ng), o_if_ready, win_if);
                chk($sformatf("t3_grant%0d_dm", ng), o_dm_ready, !win_if);
                mcnt = win_if ? 0 : mcnt + 1;
                ng++;
            end
            nxt();
        end
        chk("t3_grant_count", ng, 10);
        i_if_req = 1'b0; i_dm_req = 1'b0;
        nxt();
        nxt();
        settle();
        chk("t3_last_if_rvalid", o_if_rvalid, 1);
        nxt();
        clr();

        // ---------------- memory stall ----------------
        i_dm_req = 1'b1; i_dm_addr = 32'h3000;
        settle();
        chk("t4_dm_ready", o_dm_ready, 1);
        nxt();
        i_dm_req = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h500;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("t4_stall_mem_req",  o_mem_req,  1);
            chk("t4_stall_mem_addr", o_mem_addr, 32'h3000);
            chk("t4_stall_mem_we",   o_mem_we,   0);
            chk("t4_stall_dm_ready", o_dm_ready, 0);
            chk("t4_stall_if_ready", o_if_ready, 0);
            nxt();
        end
        i_mem_gnt = 1'b1;
        settle();
        chk("t4_gnt_mem_req", o_mem_req, 1);
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFEF00D;
        settle();
        chk("t4_resp_if_ready", o_if_ready, 0);
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t4_dm_rvalid",   o_dm_rvalid, 1);
        chk("t4_dm_rdata",    o_dm_rdata,  32'hCAFEF00D);
        chk("t4_b2b_if_ready", o_if_ready, 1);
        nxt();
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        settle();
        chk("t4_if_mem_addr", o_mem_addr, 32'h500);
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h11;
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t4_if_rvalid", o_if_rvalid, 1);
        chk("t4_if_rdata",  o_if_rdata,  32'h11);
        nxt();

        // ---------------- flush during RESP ----------------
        i_if_req = 1'b1; i_if_addr = 32'h200;
        nxt();
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        nxt();
        i_mem_gnt = 1'b0; i_if_flush = 1'b1;
        nxt();
        i_if_flush = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77;
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t5_flushed_if_rvalid", o_if_rvalid, 0);
        chk("t5_flushed_if_rdata",  o_if_rdata,  0);
        nxt();

        // flush in IDLE together with a new fetch: accepted, returns normally
        i_if_req = 1'b1; i_if_addr = 32'h204; i_if_flush = 1'b1;
        settle();
        chk("t5_idle_flush_if_ready", o_if_ready, 1);
        nxt();
        i_if_req = 1'b0; i_if_flush = 1'b0; i_mem_gnt = 1'b1;
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h88;
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t5_next_if_rvalid", o_if_rvalid, 1);
        chk("t5_next_if_rdata",  o_if_rdata,  32'h88);
        nxt();

        // flush coincident with mem_rvalid
        i_if_req = 1'b1; i_if_addr = 32'h208;
        nxt();
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        nxt();
        i_mem_gnt = 1'b0; i_if_flush = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h99;
        nxt();
        i_if_flush = 1'b0; i_mem_rvalid = 1'b0;
        settle();
        chk("t5_coinc_if_rvalid", o_if_rvalid, 0);
        nxt();

        // flush while a data transaction owns the memory: no effect
        i_dm_req = 1'b1; i_dm_addr = 32'h240;
        nxt();
        i_dm_req = 1'b0; i_mem_gnt = 1'b1; i_if_flush = 1'b1;
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hAB;
        nxt();
        i_if_flush = 1'b0; i_mem_rvalid = 1'b0;
        settle();
        chk("t5_dm_flush_rvalid", o_dm_rvalid, 1);
        chk("t5_dm_flush_rdata",  o_dm_rdata,  32'hAB);
        nxt();

        // ---------------- reset mid-operation ----------------
        i_if_req = 1'b1; i_if_addr = 32'h300;
        nxt();
        i_if_req = 1'b0; i_mem_gnt = 1'b1;
        nxt();
        i_mem_gnt = 1'b0; rst = 1'b0;
        nxt();
        rst = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD;
        settle();
        chk("t6_mem_req",  o_mem_req,  0);
        chk("t6_mem_addr", o_mem_addr, 0);
        chk("t6_if_ready", o_if_ready, 0);
        chk("t6_if_rvalid_a", o_if_rvalid, 0);
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t6_if_rvalid_b", o_if_rvalid, 0);
        chk("t6_dm_rvalid_b", o_dm_rvalid, 0);
        i_dm_req = 1'b1; i_dm_addr = 32'h600;
        settle();
        chk("t6_dm_ready", o_dm_ready, 1);
        nxt();
        i_dm_req = 1'b0; i_mem_gnt = 1'b1;
        settle();
        chk("t6_mem_addr_after", o_mem_addr, 32'h600);
        nxt();
        i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h66;
        nxt();
        i_mem_rvalid = 1'b0;
        settle();
        chk("t6_dm_rvalid", o_dm_rvalid, 1);
        chk("t6_dm_rdata",  o_dm_rdata,  32'h66);
        nxt();

        // ---------------- randomised traffic vs reference model ----------------
        rst = 1'b0;
        clr();
        nxt();
        rst = 1'b1;
        mcnt = 0; phase = 0; if_hold = 1'b0; dm_hold = 1'b0; t_drop = 1'b0;
        t_if = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
        e_if_rv = 1'b0; e_dm_rv = 1'b0; e_if_rd = '0; e_dm_rd = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!if_hold && $urandom_range(0, 2) == 0) begin
                if_hold   = 1'b1;
                i_if_addr = $urandom;
            end
            if (!dm_hold && $urandom_range(0, 2) == 0) begin
                dm_hold    = 1'b1;
                i_dm_we    = $urandom_range(0, 1) == 1;
                i_dm_addr  = $urandom;
                i_dm_wdata = $urandom;
                i_dm_wstrb = SW'($urandom_range(0, 15));
            end
            i_if_req     = if_hold;
            i_dm_req     = dm_hold;
            i_if_flush   = $urandom_range(0, 5) == 0;
            i_mem_gnt    = $urandom_range(0, 2) != 0;
            i_mem_rvalid = (phase == 2) ? ($urandom_range(0, 1) == 1)
                                        : ($urandom_range(0, 3) == 0);
            i_mem_rdata  = $urandom;
            settle();

            win_dm = (phase == 0) && dm_hold && (!if_hold || mcnt < LIMIT);
            win_if = (phase == 0) && if_hold && !win_dm;
            chk("rnd_if_ready", o_if_ready, win_if);
            chk("rnd_dm_ready", o_dm_ready, win_dm);
            chk("rnd_mem_req",  o_mem_req,  phase == 1);
            if (phase == 1) begin
                chk("rnd_mem_we",    o_mem_we,    t_we);
                chk("rnd_mem_addr",  o_mem_addr,  t_addr);
                chk("rnd_mem_wdata", o_mem_wdata, t_wdata);
                chk("rnd_mem_wstrb", o_mem_wstrb, t_wstrb);
            end
            chk("rnd_if_rvalid", o_if_rvalid, e_if_rv);
            chk("rnd_if_rdata",  o_if_rdata,  e_if_rd);
            chk("rnd_dm_rvalid", o_dm_rvalid, e_dm_rv);
            chk("rnd_dm_rdata",  o_dm_rdata,  e_dm_rd);

            // advance the model to the next cycle
            e_if_rv = 1'b0; e_if_rd = '0; e_dm_rv = 1'b0; e_dm_rd = '0;
            if (phase == 0) begin
                if (win_if) begin
                    t_if = 1'b1; t_we = 1'b0; t_addr = i_if_addr;
                    t_wdata = '0; t_wstrb = '0; t_drop = 1'b0;
                    mcnt = 0;
                    if_hold = 1'b0;
                    phase = 1;
                end else if (win_dm) begin
                    t_if = 1'b0; t_we = i_dm_we; t_addr = i_dm_addr;
                    t_wdata = i_dm_wdata; t_wstrb = i_dm_wstrb; t_drop = 1'b0;
                    if (if_hold && mcnt < LIMIT) mcnt = mcnt + 1;
                    dm_hold = 1'b0;
                    phase = 1;
                end
            end else begin
                if (i_if_flush && t_if) t_drop = 1'b1;
                if (phase == 1) begin
                    if (i_mem_gnt) phase = 2;
                end else if (i_mem_rvalid) begin
                    if (t_if) begin
                        if (!t_drop) begin
                            e_if_rv = 1'b1;
                            e_if_rd = i_mem_rdata;
                        end
                    end else begin
                        e_dm_rv = 1'b1;
                        e_dm_rd = t_we ? '0 : i_mem_rdata;
                    end
                    phase = 0;
                end
            end
            nxt();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
